// File: rtl/aibcr3aux_osc_freq_mon.sv
// Divided AUX oscillator frequency monitor: counts synchronized rising edges over a
// programmable clkin window and range-checks the result. Option: AIBCR3AUX_FREQ_MON_STICKY_ERR_EN.
module aibcr3aux_osc_freq_mon #(
  parameter int WIN_W = 10,
  parameter int CNT_W = 8
) (
  input  logic             clkin,
  input  logic             irstb,
  input  logic             osc_div_in,
  input  logic             mon_en,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] cnt_lo,
  input  logic [CNT_W-1:0] cnt_hi,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_vld,
  output logic             freq_ok,
  output logic             freq_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             flush_q, flush_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             cnt_vld_q, cnt_vld_d;
  logic             freq_ok_q, freq_ok_d;
  logic             freq_err_q, freq_err_d;
  logic             busy_q, busy_d;
  logic             edge_s, last_s, in_range_s;

  assign edge_s     = s2_q & ~s3_q;
  // A captured length of 0 wraps to all-ones here, giving a 2^WIN_W cycle window
  assign last_s     = (win_cnt_q == (win_len_q - WIN_W'(1)));
  assign in_range_s = (cnt_lo <= cnt_hi) && (edge_cnt_q >= cnt_lo) && (edge_cnt_q <= cnt_hi);

  always_ff @(posedge clkin or negedge irstb) begin
    if (!irstb) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      state_q    <= ST_IDLE;
      flush_q    <= 1'b0;
      win_cnt_q  <= '0;
      win_len_q  <= '0;
      edge_cnt_q <= '0;
      cnt_out_q  <= '0;
      cnt_vld_q  <= 1'b0;
      freq_ok_q  <= 1'b0;
      freq_err_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      s1_q       <= osc_div_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      state_q    <= state_d;
      flush_q    <= flush_d;
      win_cnt_q  <= win_cnt_d;
      win_len_q  <= win_len_d;
      edge_cnt_q <= edge_cnt_d;
      cnt_out_q  <= cnt_out_d;
      cnt_vld_q  <= cnt_vld_d;
      freq_ok_q  <= freq_ok_d;
      freq_err_q <= freq_err_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    flush_d    = 1'b0;
    win_cnt_d  = win_cnt_q;
    win_len_d  = win_len_q;
    edge_cnt_d = edge_cnt_q;
    cnt_out_d  = cnt_out_q;
    cnt_vld_d  = 1'b0;
    freq_ok_d  = freq_ok_q;
    freq_err_d = freq_err_q;
    case (state_q)
      ST_IDLE: begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
`ifdef AIBCR3AUX_FREQ_MON_STICKY_ERR_EN
        freq_err_d = 1'b0;
`endif
        if (mon_en) state_d = ST_FLUSH;
        else        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        if (!mon_en) begin
          state_d = ST_IDLE;
        end else if (flush_q) begin
          state_d   = ST_COUNT;
          win_len_d = win_len;
        end else begin
          flush_d = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!mon_en) begin
          state_d = ST_IDLE;
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          if (edge_s && (edge_cnt_q != CNT_MAX)) edge_cnt_d = edge_cnt_q + CNT_W'(1);
          else                                   edge_cnt_d = edge_cnt_q;
          if (last_s) state_d = ST_DONE;
          else        state_d = ST_COUNT;
        end
      end
      ST_DONE: begin
        cnt_out_d  = edge_cnt_q;
        cnt_vld_d  = 1'b1;
        freq_ok_d  = in_range_s;
`ifdef AIBCR3AUX_FREQ_MON_STICKY_ERR_EN
        freq_err_d = freq_err_q | ~in_range_s;
`else
        freq_err_d = ~in_range_s;
`endif
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        if (mon_en) begin
          state_d   = ST_COUNT;
          win_len_d = win_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign cnt_out  = cnt_out_q;
  assign cnt_vld  = cnt_vld_q;
  assign freq_ok  = freq_ok_q;
  assign freq_err = freq_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_aibcr3aux_osc_freq_mon.sv
// Self-checking bench for aibcr3aux_osc_freq_mon: scoreboard of expected window
// results plus per-scenario latency, abort and reset checks.
module tb_aibcr3aux_osc_freq_mon;
  localparam int WIN_W = 10;
  localparam int CNT_W = 8;
`ifdef AIBCR3AUX_FREQ_MON_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  typedef struct {
    int cnt;
    int tol;
    bit ok;
    bit err;
    bit chk;
  } exp_t;

  logic             clkin = 1'b0;
  logic             irstb;
  logic             osc_div_in;
  logic             mon_en;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] cnt_lo;
  logic [CNT_W-1:0] cnt_hi;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_vld;
  logic             freq_ok;
  logic             freq_err;
  logic             busy;

  int   errors = 0;
  int   checks = 0;
  int   osc_period = 8;
  exp_t sb_q[$];

  aibcr3aux_osc_freq_mon #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clkin     (clkin),
    .irstb     (irstb),
    .osc_div_in(osc_div_in),
    .mon_en    (mon_en),
    .win_len   (win_len),
    .cnt_lo    (cnt_lo),
    .cnt_hi    (cnt_hi),
    .cnt_out   (cnt_out),
    .cnt_vld   (cnt_vld),
    .freq_ok   (freq_ok),
    .freq_err  (freq_err),
    .busy      (busy)
  );

  initial forever #5 clkin = ~clkin;

  // divided oscillator model: 50% duty square wave of osc_period clkin cycles
  initial begin
    int ph;
    ph = 0;
    osc_div_in = 1'b0;
    forever begin
      @(negedge clkin);
      ph = ph + 1;
      if (ph >= osc_period) ph = 0;
      osc_div_in = (ph < osc_period / 2);
    end
  end

  // scoreboard: every cnt_vld pulse must match the oldest pending expectation
  always @(negedge clkin) begin
    if (cnt_vld === 1'b1) begin
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got cnt_vld=1 cnt_out=%0d, required no result", cnt_out);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) begin
          if ($isunknown(cnt_out) || int'(cnt_out) < e.cnt - e.tol || int'(cnt_out) > e.cnt + e.tol) begin
            errors++;
            $display("FAIL sb_cnt_out: got %0d, required %0d +/- %0d", cnt_out, e.cnt, e.tol);
          end
          checks++;
          if (freq_ok !== e.ok) begin
            errors++;
            $display("FAIL sb_freq_ok: got %b, required %b", freq_ok, e.ok);
          end
          checks++;
          if (freq_err !== e.err) begin
            errors++;
            $display("FAIL sb_freq_err: got %b, required %b", freq_err, e.err);
          end
        end
      end
    end
  end

  task automatic wait_vld(input int budget, output int n, output bit got);
    got = 1'b0;
    n = 0;
    while (!got && n < budget) begin
      @(negedge clkin);
      n++;
      if (cnt_vld === 1'b1) got = 1'b1;
    end
  endtask

  task automatic push_exp(input int cnt, input int tol, input bit ok, input bit err, input bit chk);
    exp_t e;
    e.cnt = cnt; e.tol = tol; e.ok = ok; e.err = err; e.chk = chk;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    irstb = 1'b0; mon_en = 1'b0; win_len = '0; cnt_lo = '0; cnt_hi = '0;
    repeat (3) @(negedge clkin);
    irstb = 1'b1;
    @(negedge clkin);
    checks++; if (cnt_out !== 8'd0)  begin errors++; $display("FAIL rst_cnt_out: got %0d, required 0", cnt_out); end
    checks++; if (cnt_vld !== 1'b0)  begin errors++; $display("FAIL rst_cnt_vld: got %b, required 0", cnt_vld); end
    checks++; if (freq_ok !== 1'b0)  begin errors++; $display("FAIL rst_freq_ok: got %b, required 0", freq_ok); end
    checks++; if (freq_err !== 1'b0) begin errors++; $display("FAIL rst_freq_err: got %b, required 0", freq_err); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
  endtask

  task automatic test_nominal();
    int n; bit got;
    osc_period = 8; win_len = 10'd64; cnt_lo = 8'd7; cnt_hi = 8'd9;
    repeat (20) @(negedge clkin);
    push_exp(8, 1, 1'b1, 1'b0, 1'b1);
    mon_en = 1'b1;
    @(negedge clkin);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_rise: got %b, required 1", busy); end
    wait_vld(200, n, got);
    checks++; if (!got || n != 67) begin errors++; $display("FAIL nom_first_latency: got %0d (seen=%0b), required 67", n, got); end
    push_exp(8, 1, 1'b1, 1'b0, 1'b1);
    @(negedge clkin);
    checks++; if (cnt_vld !== 1'b0) begin errors++; $display("FAIL nom_vld_width: got %b, required 0", cnt_vld); end
    wait_vld(200, n, got);
    checks++; if (!got || n != 64) begin errors++; $display("FAIL nom_repeat_period: got %0d (seen=%0b), required 64", n + 1, got); end
    mon_en = 1'b0;
    repeat (4) @(negedge clkin);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy_idle: got %b, required 0", busy); end
  endtask

  task automatic test_out_of_range();
    int n; bit got;
    osc_period = 16;
    repeat (20) @(negedge clkin);
    push_exp(4, 1, 1'b0, 1'b1, 1'b1);
    mon_en = 1'b1;
    wait_vld(200, n, got);
    checks++; if (!got) begin errors++; $display("FAIL oor_result: got no cnt_vld in %0d cycles, required one", n); end
    osc_period = 8;
    push_exp(0, 0, 1'b0, 1'b0, 1'b0);
    wait_vld(200, n, got);
    checks++; if (!got) begin errors++; $display("FAIL oor_transition: got no cnt_vld in %0d cycles, required one", n); end
    push_exp(8, 1, 1'b1, STICKY, 1'b1);
    wait_vld(200, n, got);
    checks++; if (!got) begin errors++; $display("FAIL oor_restore: got no cnt_vld in %0d cycles, required one", n); end
  endtask

  task automatic test_abort();
    int vld_seen;
    repeat (29) @(negedge clkin);
    mon_en = 1'b0;
    @(negedge clkin);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    vld_seen = 0;
    repeat (150) begin
      @(negedge clkin);
      if (cnt_vld === 1'b1) vld_seen++;
    end
    checks++; if (vld_seen != 0) begin errors++; $display("FAIL abort_no_vld: got %0d pulses, required 0", vld_seen); end
    checks++;
    if ($isunknown(cnt_out) || cnt_out < 8'd7 || cnt_out > 8'd9) begin
      errors++; $display("FAIL abort_cnt_hold: got %0d, required 8 +/- 1", cnt_out);
    end
    checks++; if (freq_ok !== 1'b1)  begin errors++; $display("FAIL abort_ok_hold: got %b, required 1", freq_ok); end
    checks++; if (freq_err !== 1'b0) begin errors++; $display("FAIL abort_err_hold: got %b, required 0", freq_err); end
  endtask

  task automatic test_saturation();
    int n; bit got;
    osc_period = 4; win_len = 10'd0; cnt_lo = 8'd255; cnt_hi = 8'd255;
    repeat (20) @(negedge clkin);
    push_exp(255, 0, 1'b1, 1'b0, 1'b1);
    mon_en = 1'b1;
    @(negedge clkin);
    wait_vld(1200, n, got);
    checks++; if (!got || n != 1027) begin errors++; $display("FAIL sat_latency: got %0d (seen=%0b), required 1027", n, got); end
    cnt_lo = 8'd0; cnt_hi = 8'd254;
    push_exp(255, 0, 1'b0, 1'b1, 1'b1);
    wait_vld(1200, n, got);
    checks++; if (!got || n != 1025) begin errors++; $display("FAIL sat_period: got %0d (seen=%0b), required 1025", n, got); end
  endtask

  task automatic test_reset_mid_count();
    int n; bit got;
    repeat (10) @(negedge clkin);
    #2 irstb = 1'b0;
    #1;
    checks++; if (cnt_out !== 8'd0)  begin errors++; $display("FAIL arst_cnt_out: got %0d, required 0", cnt_out); end
    checks++; if (freq_ok !== 1'b0)  begin errors++; $display("FAIL arst_freq_ok: got %b, required 0", freq_ok); end
    checks++; if (freq_err !== 1'b0) begin errors++; $display("FAIL arst_freq_err: got %b, required 0", freq_err); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL arst_busy: got %b, required 0", busy); end
    checks++; if (cnt_vld !== 1'b0)  begin errors++; $display("FAIL arst_cnt_vld: got %b, required 0", cnt_vld); end
    mon_en = 1'b0;
    @(negedge clkin);
    irstb = 1'b1;
    repeat (3) @(negedge clkin);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_idle: got busy=%b, required 0", busy); end
    osc_period = 8; win_len = 10'd64; cnt_lo = 8'd7; cnt_hi = 8'd9;
    repeat (10) @(negedge clkin);
    push_exp(8, 1, 1'b1, 1'b0, 1'b1);
    mon_en = 1'b1;
    @(negedge clkin);
    wait_vld(200, n, got);
    checks++; if (!got || n != 67) begin errors++; $display("FAIL arst_restart_latency: got %0d (seen=%0b), required 67", n, got); end
    mon_en = 1'b0;
    repeat (5) @(negedge clkin);
  endtask

  initial begin
    irstb = 1'b0; mon_en = 1'b0; win_len = '0; cnt_lo = '0; cnt_hi = '0;
    test_reset();
    test_nominal();
    test_out_of_range();
    test_abort();
    test_saturation();
    test_reset_mid_count();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending results, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aibcr3aux_osc_freq_mon.md
# aibcr3aux_osc_freq_mon

Frequency monitor for the divided AUX oscillator clock, running in the reference clock domain. The divided clock is treated as data: it is synchronized, and its rising edges are counted over a programmable window of reference clock cycles. Each window's count is compared against a low/high bound, and the block reports pass or fail. It sits downstream of the oscillator divide-by-2 stage, as the checking end of that clock path for bring-up and in-field health monitoring.

## Interface
Parameters:
- WIN_W, 10: width of the window length, in reference cycles.
- CNT_W, 8: width of the edge count and of the bounds.

Ports:
- clkin  input  1: reference clock; the only clock in the block.
- irstb  input  1: asynchronous active-low reset.
- osc_div_in  input  1: divided oscillator clock, asynchronous to clkin; sampled as data.
- mon_en  input  1: level enable; high = monitor continuously.
- win_len  input  WIN_W: window length in clkin cycles.
- cnt_lo  input  CNT_W: inclusive lower bound.
- cnt_hi  input  CNT_W: inclusive upper bound.
- cnt_out  output  CNT_W: edge count of the last completed window.
- cnt_vld  output  1: one-cycle pulse when cnt_out updates.
- freq_ok  output  1: last window was in range.
- freq_err  output  1: last window was out of range.
- busy  output  1: FSM is not in IDLE.

## Operation
- Synchronizer: osc_div_in passes through s1→s2. A history flop s3 follows s2. Rising edge = s2 & ~s3.
- FSM states: IDLE, FLUSH, COUNT, DONE.
- IDLE: all counters are cleared. mon_en=1 → FLUSH.
- FLUSH: lasts exactly 2 cycles so stale synchronizer contents are discarded. The edge counter is held at 0. After 2 cycles → COUNT.
- COUNT:
  - win_len is captured on entry to COUNT.
  - win_len=0 is treated as 2^WIN_W cycles.
  - The window counter increments every cycle.
  - The edge counter increments on each detected edge and saturates at 2^CNT_W−1.
  - After the last window cycle → DONE.
- DONE lasts 1 cycle:
  - cnt_out is loaded with the edge count.
  - cnt_vld=1.
  - freq_ok = (cnt_lo ≤ cnt ≤ cnt_hi). freq_err = ~freq_ok.
  - If cnt_lo > cnt_hi, then freq_ok=0 and freq_err=1.
  - Then: mon_en=1 → COUNT with both counters cleared (no re-flush). mon_en=0 → IDLE.
- mon_en=0 in FLUSH or COUNT: abort to IDLE on the next cycle. There is no cnt_vld, and cnt_out, freq_ok and freq_err hold their previous values.
- cnt_lo and cnt_hi are sampled only in DONE.
- The count is accurate only when the osc_div_in frequency is below clkin/2, because each high phase and each low phase must last at least 1 clkin period.

## Timing
- Reset values: cnt_out=0, cnt_vld=0, freq_ok=0, freq_err=0, busy=0. FSM=IDLE. s1, s2 and s3 are 0.
- busy rises 1 cycle after mon_en rises.
- Detection latency: an edge at osc_div_in reaches the counter 3 clkin edges later (s1, s2, then the count register).
- First result: cnt_vld asserts 2 + L + 1 cycles after FLUSH entry, where L is the effective window length.
- Continuous mode: results repeat every L+1 cycles.
- Phase boundaries:
  - An edge detected in the final COUNT cycle is counted.
  - An edge detected in DONE is not counted.
  - Consequently, ±1 count jitter between windows is expected.

## Configuration
- Macro: AIBCR3AUX_FREQ_MON_STICKY_ERR_EN.
- Defined: freq_err is sticky. Once set, it stays 1 until the FSM returns to IDLE (mon_en=0 or reset). freq_ok still reflects only the last window.
- Undefined: freq_err reflects only the last completed window.

## Test plan
- Reset check: assert irstb=0 mid-COUNT → all outputs drop to 0 asynchronously, and FSM is IDLE after irstb rises.
- Nominal count: osc_div_in period 8 clkin, win_len=64, cnt_lo=7, cnt_hi=9 → cnt_out is 8 (±1), freq_ok=1, and cnt_vld first pulses at cycle 67 after FLUSH entry.
- Out of range: osc_div_in period 16, win_len=64, cnt_lo=7, cnt_hi=9 → cnt_out=4, freq_err=1. Restore period 8 → next window gives freq_ok=1; freq_err stays 1 only with AIBCR3AUX_FREQ_MON_STICKY_ERR_EN.
- Saturation and win_len=0: CNT_W=4, osc_div_in period 4, win_len=0 (window of 1024 cycles) → cnt_out=15.
- Abort: drop mon_en at cycle 30 of a 64-cycle window → no cnt_vld; the prior cnt_out, freq_ok and freq_err are held; busy=0 one cycle later.
